// File: rtl/master_led_controller.sv
// master_led_controller
//   Status display for the multi-core RC4 key search. Latches which cores
//   reported success, lights an aggregate "found" LED, and flags a failed
//   search on LEDR[9].
//
//   Optional feature macro: FAILURE_BLINK_EN
//     defined   -> LEDR[9] blinks in FAILURE, BLINK_DIV cycles per half-period
//     undefined -> LEDR[9] held steady at 1 in FAILURE (no blink logic built)
//
//   Ports:
//     clk           in   system clock, rising edge
//     reset         in   synchronous active-high reset
//     success_state in   [3:0] per-core success flags
//     failure       in   global search-failed flag
//     LEDR          out  [9:0] registered board LEDs
module master_led_controller #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] success_state,
  input  logic       failure,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUCCESS = 2'd1,
    S_FAILURE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [9:0] ledr_q, ledr_d;

`ifdef FAILURE_BLINK_EN
  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
`endif

  // State / data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= 4'b0;
      ledr_q  <= 10'b0;
`ifdef FAILURE_BLINK_EN
      cnt_q   <= '0;
      phase_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ledr_q  <= ledr_d;
`ifdef FAILURE_BLINK_EN
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
`endif
    end
  end

  // Next-state logic: any success wins over failure; SUCCESS is absorbing,
  // FAILURE is sticky until a success or reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (success_state != 4'b0) state_d = S_SUCCESS;
        else if (failure)          state_d = S_FAILURE;
      end
      S_SUCCESS: state_d = S_SUCCESS;
      S_FAILURE: begin
        if (success_state != 4'b0) state_d = S_SUCCESS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. LEDs are computed from the next-state values so
  // the registered LEDR reflects bits captured on the same edge.
  always_comb begin
    mask_d = mask_q;
    ledr_d = 10'b0;
    if (state_d == S_SUCCESS) mask_d = mask_q | success_state;

`ifdef FAILURE_BLINK_EN
    cnt_d   = '0;
    phase_d = 1'b1;
    // Counter only runs while remaining in FAILURE; entering restarts at
    // phase 1 so the LED is lit on the entry edge.
    if (state_q == S_FAILURE && state_d == S_FAILURE) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
`endif

    unique case (state_d)
      S_SUCCESS: begin
        ledr_d[3:0] = mask_d;
        ledr_d[8]   = 1'b1;
      end
      S_FAILURE: begin
`ifdef FAILURE_BLINK_EN
        ledr_d[9] = phase_d;
`else
        ledr_d[9] = 1'b1;
`endif
      end
      default: ledr_d = 10'b0;
    endcase
  end

  assign LEDR = ledr_q;

endmodule

// File: tb/tb_master_led_controller.sv
module tb_master_led_controller;

  localparam int BLINK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] success_state;
  logic       failure;
  logic [9:0] LEDR;

  int checks = 0;
  int errors = 0;

  master_led_controller #(.BLINK_DIV(BLINK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .success_state(success_state),
    .failure      (failure),
    .LEDR         (LEDR)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [9:0] exp);
    checks++;
    assert (LEDR === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, LEDR, exp);
      end
  endtask

  initial begin
    reset = 1'b1;
    success_state = 4'd0;
    failure = 1'b0;
    @(negedge clk);
    step();
    check("reset", 10'h000);

    // Idle for 20 cycles
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", 10'h000);
    end

    // Single-cycle success pulse on core 0, then sticky
    success_state = 4'd1;
    step();
    check("succ1_first", 10'h101);
    success_state = 4'd0;
    for (int i = 0; i < 19; i++) begin
      step();
      check("succ1_sticky", 10'h101);
    end

    // Further cores accumulate
    success_state = 4'd2;
    step();
    check("succ2_first", 10'h103);
    success_state = 4'd0;
    for (int i = 0; i < 19; i++) begin
      step();
      check("succ2_sticky", 10'h103);
    end
    success_state = 4'd4;
    step();
    check("succ4_first", 10'h107);
    success_state = 4'd0;
    for (int i = 0; i < 19; i++) begin
      step();
      check("succ4_sticky", 10'h107);
    end
    success_state = 4'd8;
    step();
    check("succ8_first", 10'h10F);
    success_state = 4'd0;
    for (int i = 0; i < 19; i++) begin
      step();
      check("succ8_sticky", 10'h10F);
    end

    // Failure ignored in SUCCESS
    failure = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("succ_ignores_fail", 10'h10F);
    end

    // Reset from SUCCESS, then failure-only search
    reset = 1'b1;
    step();
    check("reset_from_succ", 10'h000);
    reset = 1'b0;
`ifdef FAILURE_BLINK_EN
    // Lit for BLINK_DIV cycles, dark for BLINK_DIV cycles, repeating
    for (int i = 0; i < 4 * BLINK_DIV; i++) begin
      step();
      check("fail_blink", ((i / BLINK_DIV) % 2 == 0) ? 10'h200 : 10'h000);
    end
    // Blink keeps going after failure drops
    failure = 1'b0;
    for (int i = 4 * BLINK_DIV; i < 6 * BLINK_DIV; i++) begin
      step();
      check("fail_sticky_blink", ((i / BLINK_DIV) % 2 == 0) ? 10'h200 : 10'h000);
    end
`else
    for (int i = 0; i < 4 * BLINK_DIV; i++) begin
      step();
      check("fail_steady", 10'h200);
    end
    failure = 1'b0;
    for (int i = 0; i < 2 * BLINK_DIV; i++) begin
      step();
      check("fail_sticky", 10'h200);
    end
`endif

    // Success overrides failure
    success_state = 4'd4;
    step();
    check("fail_to_succ", 10'h104);
    success_state = 4'd0;
    step();
    check("fail_to_succ_hold", 10'h104);

    // Build full mask, then reset and simultaneous fail+success
    success_state = 4'hB;
    step();
    check("mask_full", 10'h10F);
    reset = 1'b1;
    success_state = 4'd0;
    step();
    check("reset_mask_f", 10'h000);
    reset = 1'b0;
    failure = 1'b1;
    success_state = 4'd8;
    step();
    check("simul_fail_succ", 10'h108);
    success_state = 4'd0;
    step();
    check("simul_hold", 10'h108);

    // Reset priority over active inputs
    reset = 1'b1;
    success_state = 4'd3;
    step();
    check("reset_priority", 10'h000);
    step();
    check("reset_priority_hold", 10'h000);

    // IDLE: failure with success=0 goes to FAILURE, LED lit on entry edge
    reset = 1'b0;
    success_state = 4'd0;
    failure = 1'b1;
    step();
    check("fail_entry", 10'h200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
